// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational 8-bit ALU between two requesters.
// Operands/opcode are registered, held for ALU_LAT cycles, then result and flags are captured.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp_f,
  output logic [5:0] rsp_flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_s,
  input  logic [7:0] alu_f,
  input  logic       alu_equal,
  input  logic       alu_gt,
  input  logic       alu_lt,
  input  logic       alu_zero,
  input  logic       alu_cout,
  input  logic       alu_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t     state, state_nxt;
  logic       prio;
  logic       owner;
  logic       grant;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;
  logic       release_rsp;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    // A lone requester wins outright; on contention the priority pointer decides.
    grant       = (req0_valid && req1_valid) ? prio : req1_valid;

    case (state)
      IDLE: begin
        req0_ready = !rst && req0_valid && !grant;
        req1_ready = !rst && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp0_valid  = !owner;
        rsp1_valid  = owner;
        release_rsp = owner ? rsp1_ready : rsp0_ready;
        if (release_rsp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= 1'b0;
      owner     <= 1'b0;
      cnt       <= 4'd0;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_s     <= 4'h0;
      rsp_f     <= 8'h00;
      rsp_flags <= 6'h00;
    end else begin
      // ALU inputs change only at a request handshake and are held otherwise.
      if (accept) begin
        owner <= grant;
        alu_s <= grant ? req1_op : req0_op;
        alu_a <= grant ? req1_a  : req0_a;
        alu_b <= grant ? req1_b  : req0_b;
        cnt   <= LAT_M1;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (capture) begin
        rsp_f     <= alu_f;
        rsp_flags <= {alu_equal, alu_gt, alu_lt, alu_zero, alu_cout, alu_ovf};
      end

      if (release_rsp) prio <= ~owner;
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational 8-bit ALU between two independent requesters. It accepts one operation at a time over a valid/ready request channel, drives the ALU operand and opcode lines from registers, and waits a fixed settle time. It then captures the result and flags and returns them on the winning requester's valid/ready response channel. It sits between the ALU instance and two upstream masters, for example an instruction decoder and a DMA/test port.

## Interface
- ALU_LAT, default 1: cycles ALU inputs are held before the result is sampled; legal range 1–15.
- CLK  in  1  single clock; all state changes on rising edge.
- RST  in  1  reset; synchronous, active-high.
- REQ0_VALID, REQ1_VALID  in  1  requester n presents an operation.
- REQ0_READY, REQ1_READY  out  1  request accepted when VALID & READY are high at a rising edge.
- REQ0_OP, REQ1_OP  in  4  ALU opcode S[3:0].
- REQ0_A, REQ0_B, REQ1_A, REQ1_B  in  8  operands.
- RSP0_VALID, RSP1_VALID  out  1  response holding.
- RSP0_READY, RSP1_READY  in  1  requester consumes response.
- RSP_F  out  8  captured result, shared by both ports and qualified by RSPn_VALID.
- RSP_FLAGS  out  6  captured {EQUAL,GT,LT,Zero,CarryOut,Overflow}.
- ALU_A, ALU_B  out  8  to ALU operands.
- ALU_S  out  4  to ALU opcode.
- ALU_F  in  8  ALU combinational result.
- ALU_EQUAL, ALU_GT, ALU_LT, ALU_ZERO, ALU_COUT, ALU_OVF  in  1  ALU flags.

## Operation
- Opcode encoding passed through unmodified:
  - S[3]=0 selects arithmetic: 00 A+B, 01 A−B, 10 B, 11 −B.
  - S[3:2]=10 selects logic: 00 AND, 01 XOR, 10 OR, 11 NOT B.
  - S[3:2]=11 selects shift of A: 00 ROR, 01 ROL, 10 SHR, 11 SHL.
- FSM states are IDLE, EXEC and RESP.
  - IDLE: compute grant. If only one VALID is high, that port wins. If both are high, the port with priority wins.
    - READYn = (state==IDLE) & grant==n. READY may depend combinationally on VALID.
    - On handshake: load OP/A/B into the ALU_S/ALU_A/ALU_B registers, record the owner, load wait counter = ALU_LAT−1, go to EXEC.
  - EXEC: ALU outputs are held constant.
    - Counter ≠ 0: decrement.
    - Counter = 0: capture ALU_F into RSP_F and the flags into RSP_FLAGS, go to RESP.
  - RESP: RSP<owner>_VALID=1. On RSP<owner>_READY: clear VALID, flip priority to the non-owner, go to IDLE.
- Priority pointer: after port n's response completes, port 1−n has priority. Reset gives port 0 priority.
- The non-owner's RSP_VALID is always 0; RSPn_READY from the non-owner is ignored.
- Requests arriving in EXEC or RESP wait with READY low. Upstream must hold VALID and its payload stable until the handshake.
- The block never modifies the result. Flags are exactly the ALU's outputs, including compare flags for non-arithmetic ops.

## Timing
- Reset values:
  - State IDLE, priority port 0.
  - All REQn_READY and RSPn_VALID 0.
  - RSP_F 0x00, RSP_FLAGS 0.
  - ALU_A, ALU_B 0x00; ALU_S 0x0.
- Reset asserted in any state forces all outputs to reset values at the next edge; any in-flight operation is dropped with no response.
- Request handshake at edge k:
  - ALU inputs carry the new operation from k+1.
  - Result captured at edge k+ALU_LAT.
  - RSP VALID high from k+ALU_LAT.
- Response handshake at edge r: VALID low from r; READY for the next request is possible in the cycle after r.
- Minimum request-to-request spacing is ALU_LAT+2 cycles, reached with RSP_READY held high.
- ALU_A/ALU_B/ALU_S hold their last values outside EXEC; they change only at a request handshake.
- RSP_F and RSP_FLAGS are stable for the whole time VALID is high and hold after it drops.
- Backpressure: RESP persists indefinitely while RSP<owner>_READY is low.

## Test plan
- Single op, ALU_LAT=1: REQ0 OP=0000, A=0x05, B=0x03 at edge k → ALU_A=0x05 from k+1; RSP0_VALID from k+1 with RSP_F=0x08 and Zero, CarryOut, Overflow = 0.
- Signed overflow: REQ1 OP=0000, A=0x7F, B=0x01 → RSP_F=0x80, Overflow=1, CarryOut=0. Then OP=0001, A=0x05, B=0x05 → RSP_F=0x00, Zero=1, EQUAL=1, CarryOut=1.
- Contention after reset: both VALID high with OP=1000 (AND), 0xF0/0x3C → port 0 served first with 0x30. Port 1 is served next while port 0 keeps requesting, then port 0 again (strict alternation).
- Backpressure with ALU_LAT=3: RSP0_READY low for 10 cycles → RSP0_VALID and RSP_F stay stable and REQ1_READY stays 0 throughout. Release → REQ1_READY rises the following cycle.
- Reset mid-EXEC: assert RST during EXEC with ALU_LAT=4 → no RSP_VALID ever appears for that op, all outputs are 0 after the edge, and port 0 has priority.
- Shift path: REQ0 OP=1111 (SHL), A=0x81 → RSP_F=0x02. OP=1100 (ROR), A=0x01 → RSP_F=0x80.
